// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the 5-stage RV32I pipeline: decode control bundle,
// opcode map and the action selected by the ID/EX register each cycle.
package riscv_pipe_pkg;

    typedef struct packed {
        logic       alu_src;
        logic [1:0] reg_wb_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
        logic [1:0] ctrl_transfer;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_STALL = 2'd1,
        ACT_HOLD  = 2'd2,
        ACT_FLUSH = 2'd3
    } stage_act_e;

    // True when the bundle would change architectural state (a bubble never does).
    function automatic logic ctrl_has_effect(input ctrl_t c);
        return c.reg_write | c.mem_read | c.mem_write | (c.ctrl_transfer != 2'b00);
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// Bundle of ID-side inputs, EX-side outputs, stall feedback and perf counters
// exchanged by the ID/EX pipeline register.
interface id_ex_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    import riscv_pipe_pkg::*;

    logic             id_valid;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_rd1;
    logic [XLEN-1:0]  id_rd2;
    logic [XLEN-1:0]  id_imm;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic [2:0]       id_funct3;
    logic [6:0]       id_funct7;
    ctrl_t            id_ctrl;
    logic             ex_flush;
    logic             ex_hold;

    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_rd1;
    logic [XLEN-1:0]  ex_rd2;
    logic [XLEN-1:0]  ex_imm;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic [2:0]       ex_funct3;
    logic [6:0]       ex_funct7;
    ctrl_t            ex_ctrl;
    logic             stall_if_id;
    logic [CNT_W-1:0] perf_stall_cnt;
    logic [CNT_W-1:0] perf_flush_cnt;

    modport slave (
        input  id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
               id_funct3, id_funct7, id_ctrl, ex_flush, ex_hold,
        output ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_funct3, ex_funct7, ex_ctrl, stall_if_id, perf_stall_cnt, perf_flush_cnt
    );

    modport master (
        output id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
               id_funct3, id_funct7, id_ctrl, ex_flush, ex_hold,
        input  ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_funct3, ex_funct7, ex_ctrl, stall_if_id, perf_stall_cnt, perf_flush_cnt
    );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is read by
// the instruction in ID as a register operand (rs2 only matters for R-type or stores).
module load_use_detect (
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_alu_src_i,
    input  logic       id_mem_write_i,
    output logic       lu_o
);
    logic hit_rs1_s;
    logic hit_rs2_s;

    assign hit_rs1_s = (ex_rd_i == id_rs1_i);
    assign hit_rs2_s = (ex_rd_i == id_rs2_i) & (~id_alu_src_i | id_mem_write_i);
    assign lu_o      = ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) & id_valid_i
                     & (hit_rs1_s | hit_rs2_s);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush squashing, downstream
// hold and saturating stall/flush performance counters.
module id_ex_stage_reg
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic   clk,
    input  logic   reset,
    id_ex_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic       lu_s;
    stage_act_e act_s;

    logic             ex_valid_q,  ex_valid_d;
    logic [XLEN-1:0]  ex_pc_q,     ex_pc_d;
    logic [XLEN-1:0]  ex_rd1_q,    ex_rd1_d;
    logic [XLEN-1:0]  ex_rd2_q,    ex_rd2_d;
    logic [XLEN-1:0]  ex_imm_q,    ex_imm_d;
    logic [4:0]       ex_rs1_q,    ex_rs1_d;
    logic [4:0]       ex_rs2_q,    ex_rs2_d;
    logic [4:0]       ex_rd_q,     ex_rd_d;
    logic [2:0]       ex_funct3_q, ex_funct3_d;
    logic [6:0]       ex_funct7_q, ex_funct7_d;
    ctrl_t            ex_ctrl_q,   ex_ctrl_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    load_use_detect u_load_use_detect (
        .ex_valid_i     (ex_valid_q),
        .ex_mem_read_i  (ex_ctrl_q.mem_read),
        .ex_rd_i        (ex_rd_q),
        .id_valid_i     (bus.id_valid),
        .id_rs1_i       (bus.id_rs1),
        .id_rs2_i       (bus.id_rs2),
        .id_alu_src_i   (bus.id_ctrl.alu_src),
        .id_mem_write_i (bus.id_ctrl.mem_write),
        .lu_o           (lu_s)
    );

    // Per-cycle action: flush beats hold beats load-use bubble beats normal capture.
    always_comb begin
        act_s = ACT_LOAD;
        if (bus.ex_flush) begin
            act_s = ACT_FLUSH;
        end else if (bus.ex_hold) begin
            act_s = ACT_HOLD;
        end else if (lu_s) begin
            act_s = ACT_STALL;
        end else begin
            act_s = ACT_LOAD;
        end
    end

    assign bus.stall_if_id = ~bus.ex_flush & (bus.ex_hold | lu_s);

    // Next-state of the EX bank for the selected action.
    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_pc_d     = ex_pc_q;
        ex_rd1_d    = ex_rd1_q;
        ex_rd2_d    = ex_rd2_q;
        ex_imm_d    = ex_imm_q;
        ex_rs1_d    = ex_rs1_q;
        ex_rs2_d    = ex_rs2_q;
        ex_rd_d     = ex_rd_q;
        ex_funct3_d = ex_funct3_q;
        ex_funct7_d = ex_funct7_q;
        ex_ctrl_d   = ex_ctrl_q;
        case (act_s)
            ACT_HOLD: begin
                ex_valid_d = ex_valid_q;
            end
            ACT_LOAD: begin
                ex_valid_d  = bus.id_valid;
                ex_pc_d     = bus.id_pc;
                ex_rd1_d    = bus.id_rd1;
                ex_rd2_d    = bus.id_rd2;
                ex_imm_d    = bus.id_imm;
                ex_rs1_d    = bus.id_rs1;
                ex_rs2_d    = bus.id_rs2;
                ex_rd_d     = bus.id_rd;
                ex_funct3_d = bus.id_funct3;
                ex_funct7_d = bus.id_funct7;
                ex_ctrl_d   = bus.id_valid ? bus.id_ctrl : CTRL_BUBBLE;
            end
            default: begin
                ex_valid_d  = 1'b0;
                ex_pc_d     = '0;
                ex_rd1_d    = '0;
                ex_rd2_d    = '0;
                ex_imm_d    = '0;
                ex_rs1_d    = 5'd0;
                ex_rs2_d    = 5'd0;
                ex_rd_d     = 5'd0;
                ex_funct3_d = 3'd0;
                ex_funct7_d = 7'd0;
                ex_ctrl_d   = CTRL_BUBBLE;
            end
        endcase
    end

    // EX register bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q  <= 1'b0;
            ex_pc_q     <= '0;
            ex_rd1_q    <= '0;
            ex_rd2_q    <= '0;
            ex_imm_q    <= '0;
            ex_rs1_q    <= 5'd0;
            ex_rs2_q    <= 5'd0;
            ex_rd_q     <= 5'd0;
            ex_funct3_q <= 3'd0;
            ex_funct7_q <= 7'd0;
            ex_ctrl_q   <= CTRL_BUBBLE;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_pc_q     <= ex_pc_d;
            ex_rd1_q    <= ex_rd1_d;
            ex_rd2_q    <= ex_rd2_d;
            ex_imm_q    <= ex_imm_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_rd_q     <= ex_rd_d;
            ex_funct3_q <= ex_funct3_d;
            ex_funct7_q <= ex_funct7_d;
            ex_ctrl_q   <= ex_ctrl_d;
        end
    end

    // Saturating counter increments; held at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((act_s == ACT_STALL) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if ((act_s == ACT_FLUSH) && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.ex_valid       = ex_valid_q;
    assign bus.ex_pc          = ex_pc_q;
    assign bus.ex_rd1         = ex_rd1_q;
    assign bus.ex_rd2         = ex_rd2_q;
    assign bus.ex_imm         = ex_imm_q;
    assign bus.ex_rs1         = ex_rs1_q;
    assign bus.ex_rs2         = ex_rs2_q;
    assign bus.ex_rd          = ex_rd_q;
    assign bus.ex_funct3      = ex_funct3_q;
    assign bus.ex_funct7      = ex_funct7_q;
    assign bus.ex_ctrl        = ex_ctrl_q;
    assign bus.perf_stall_cnt = stall_cnt_q;
    assign bus.perf_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: table of vectors through a scoreboard queue, plus
// hand-written saturation (second instance with 4-bit counters) and async reset sequences.
module tb_id_ex_stage_reg;
    import riscv_pipe_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    id_ex_if #(.XLEN(32), .CNT_W(16)) bus ();
    id_ex_if #(.XLEN(32), .CNT_W(4))  bus_s ();

    id_ex_stage_reg #(.XLEN(32), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    id_ex_stage_reg #(.XLEN(32), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    assign bus_s.id_valid  = bus.id_valid;
    assign bus_s.id_pc     = bus.id_pc;
    assign bus_s.id_rd1    = bus.id_rd1;
    assign bus_s.id_rd2    = bus.id_rd2;
    assign bus_s.id_imm    = bus.id_imm;
    assign bus_s.id_rs1    = bus.id_rs1;
    assign bus_s.id_rs2    = bus.id_rs2;
    assign bus_s.id_rd     = bus.id_rd;
    assign bus_s.id_funct3 = bus.id_funct3;
    assign bus_s.id_funct7 = bus.id_funct7;
    assign bus_s.id_ctrl   = bus.id_ctrl;
    assign bus_s.ex_flush  = bus.ex_flush;
    assign bus_s.ex_hold   = bus.ex_hold;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam ctrl_t C_ADD  = '{alu_src:1'b0, reg_wb_src:2'b00, reg_write:1'b1, mem_read:1'b0,
                                 mem_write:1'b0, alu_op:2'b10, ctrl_transfer:2'b00};
    localparam ctrl_t C_ADDI = '{alu_src:1'b1, reg_wb_src:2'b00, reg_write:1'b1, mem_read:1'b0,
                                 mem_write:1'b0, alu_op:2'b10, ctrl_transfer:2'b00};
    localparam ctrl_t C_LW   = '{alu_src:1'b1, reg_wb_src:2'b01, reg_write:1'b1, mem_read:1'b1,
                                 mem_write:1'b0, alu_op:2'b00, ctrl_transfer:2'b00};
    localparam ctrl_t C_SW   = '{alu_src:1'b1, reg_wb_src:2'b00, reg_write:1'b0, mem_read:1'b0,
                                 mem_write:1'b1, alu_op:2'b00, ctrl_transfer:2'b00};
    localparam ctrl_t C_NOP  = '0;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        ctrl_t       ctrl;
        logic        flush;
        logic        hold;
        logic        exp_stall;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_rd1;
        logic [4:0]  exp_rd;
        ctrl_t       exp_ctrl;
        int          exp_scnt;
        int          exp_fcnt;
    } vec_t;

    typedef struct {
        int          idx;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [4:0]  rd;
        ctrl_t       ctrl;
        int          scnt;
        int          fcnt;
    } exp_t;

    localparam int NVEC = 23;
    vec_t vt[NVEC];
    exp_t sb[$];

    function automatic logic [31:0] rot16(input logic [31:0] x);
        return {x[15:0], x[31:16]};
    endfunction

    function automatic vec_t mkv(input logic v, input logic [31:0] pc, input logic [31:0] rd1,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input ctrl_t c, input logic fl, input logic ho, input logic es,
                                 input logic ev, input logic [31:0] epc, input logic [31:0] erd1,
                                 input logic [4:0] erd, input ctrl_t ec, input int esc, input int efc);
        vec_t r;
        r.valid = v; r.pc = pc; r.rd1 = rd1; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.ctrl = c;
        r.flush = fl; r.hold = ho; r.exp_stall = es; r.exp_valid = ev; r.exp_pc = epc;
        r.exp_rd1 = erd1; r.exp_rd = erd; r.exp_ctrl = ec; r.exp_scnt = esc; r.exp_fcnt = efc;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] rd1,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input ctrl_t c, input logic fl, input logic ho);
        bus.id_valid  = v;
        bus.id_pc     = pc;
        bus.id_rd1    = rd1;
        bus.id_rd2    = rot16(pc);
        bus.id_imm    = pc << 1;
        bus.id_rs1    = rs1;
        bus.id_rs2    = rs2;
        bus.id_rd     = rd;
        bus.id_funct3 = pc[4:2];
        bus.id_funct7 = rd1[6:0];
        bus.id_ctrl   = c;
        bus.ex_flush  = fl;
        bus.ex_hold   = ho;
    endtask

    task automatic step(input vec_t v, input int idx);
        exp_t e;
        exp_t g;
        @(negedge clk);
        drive(v.valid, v.pc, v.rd1, v.rs1, v.rs2, v.rd, v.ctrl, v.flush, v.hold);
        #1;
        chk($sformatf("v%0d stall_if_id", idx), 64'(bus.stall_if_id), 64'(v.exp_stall));
        e.idx = idx; e.valid = v.exp_valid; e.pc = v.exp_pc; e.rd1 = v.exp_rd1; e.rd = v.exp_rd;
        e.ctrl = v.exp_ctrl; e.scnt = v.exp_scnt; e.fcnt = v.exp_fcnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk($sformatf("v%0d ex_valid", g.idx), 64'(bus.ex_valid), 64'(g.valid));
        chk($sformatf("v%0d ex_pc", g.idx), 64'(bus.ex_pc), 64'(g.pc));
        chk($sformatf("v%0d ex_rd1", g.idx), 64'(bus.ex_rd1), 64'(g.rd1));
        chk($sformatf("v%0d ex_rd2", g.idx), 64'(bus.ex_rd2), 64'(rot16(g.pc)));
        chk($sformatf("v%0d ex_imm", g.idx), 64'(bus.ex_imm), 64'(g.pc << 1));
        chk($sformatf("v%0d ex_rd", g.idx), 64'(bus.ex_rd), 64'(g.rd));
        chk($sformatf("v%0d ex_funct3", g.idx), 64'(bus.ex_funct3), 64'(g.pc[4:2]));
        chk($sformatf("v%0d ex_funct7", g.idx), 64'(bus.ex_funct7), 64'(g.rd1[6:0]));
        chk($sformatf("v%0d ex_ctrl", g.idx), 64'(bus.ex_ctrl), 64'(g.ctrl));
        chk($sformatf("v%0d perf_stall_cnt", g.idx), 64'(bus.perf_stall_cnt), 64'(g.scnt));
        chk($sformatf("v%0d perf_flush_cnt", g.idx), 64'(bus.perf_flush_cnt), 64'(g.fcnt));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ex_valid"}, 64'(bus.ex_valid), 64'd0);
        chk({tag, " ex_pc"}, 64'(bus.ex_pc), 64'd0);
        chk({tag, " ex_rd1"}, 64'(bus.ex_rd1), 64'd0);
        chk({tag, " ex_rd"}, 64'(bus.ex_rd), 64'd0);
        chk({tag, " ex_ctrl"}, 64'(bus.ex_ctrl), 64'd0);
        chk({tag, " stall_if_id"}, 64'(bus.stall_if_id), 64'd0);
        chk({tag, " perf_stall_cnt"}, 64'(bus.perf_stall_cnt), 64'd0);
        chk({tag, " perf_flush_cnt"}, 64'(bus.perf_flush_cnt), 64'd0);
        chk({tag, " sat perf_stall_cnt"}, 64'(bus_s.perf_stall_cnt), 64'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //            v  pc      rd1      rs1 rs2 rd ctrl   fl hold st  ev epc     erd1     erd ectrl  sc fc
        vt[0]  = mkv(1, 32'h40, 32'h1234, 1, 2, 3, C_ADD,  0, 0, 0,  1, 32'h40, 32'h1234, 3, C_ADD,  0, 0);
        vt[1]  = mkv(1, 32'h44, 32'h100,  2, 0, 5, C_LW,   0, 0, 0,  1, 32'h44, 32'h100,  5, C_LW,   0, 0);
        vt[2]  = mkv(1, 32'h48, 32'h200,  5, 1, 6, C_ADD,  0, 0, 1,  0, 32'h0,  32'h0,    0, C_NOP,  1, 0);
        vt[3]  = mkv(1, 32'h48, 32'h200,  5, 1, 6, C_ADD,  0, 0, 0,  1, 32'h48, 32'h200,  6, C_ADD,  1, 0);
        vt[4]  = mkv(1, 32'h4c, 32'h300,  1, 0, 0, C_LW,   0, 0, 0,  1, 32'h4c, 32'h300,  0, C_LW,   1, 0);
        vt[5]  = mkv(1, 32'h50, 32'h400,  0, 0, 7, C_ADD,  0, 0, 0,  1, 32'h50, 32'h400,  7, C_ADD,  1, 0);
        vt[6]  = mkv(1, 32'h54, 32'h500,  3, 0, 5, C_LW,   0, 0, 0,  1, 32'h54, 32'h500,  5, C_LW,   1, 0);
        vt[7]  = mkv(1, 32'h58, 32'h600,  1, 5, 7, C_ADDI, 0, 0, 0,  1, 32'h58, 32'h600,  7, C_ADDI, 1, 0);
        vt[8]  = mkv(1, 32'h5c, 32'h700,  3, 0, 5, C_LW,   0, 0, 0,  1, 32'h5c, 32'h700,  5, C_LW,   1, 0);
        vt[9]  = mkv(1, 32'h60, 32'h800,  2, 5, 0, C_SW,   0, 0, 1,  0, 32'h0,  32'h0,    0, C_NOP,  2, 0);
        vt[10] = mkv(1, 32'h64, 32'h900,  2, 0, 5, C_LW,   0, 0, 0,  1, 32'h64, 32'h900,  5, C_LW,   2, 0);
        vt[11] = mkv(1, 32'h68, 32'ha00,  5, 1, 6, C_ADD,  1, 0, 0,  0, 32'h0,  32'h0,    0, C_NOP,  2, 1);
        vt[12] = mkv(0, 32'h6c, 32'hb00,  5, 0, 9, C_ADD,  0, 0, 0,  0, 32'h6c, 32'hb00,  9, C_NOP,  2, 1);
        vt[13] = mkv(1, 32'h70, 32'hc00,  1, 0, 5, C_LW,   0, 0, 0,  1, 32'h70, 32'hc00,  5, C_LW,   2, 1);
        vt[14] = mkv(0, 32'h74, 32'hd00,  5, 0, 8, C_ADD,  0, 0, 0,  0, 32'h74, 32'hd00,  8, C_NOP,  2, 1);
        vt[15] = mkv(1, 32'h78, 32'he00,  1, 0, 5, C_LW,   0, 0, 0,  1, 32'h78, 32'he00,  5, C_LW,   2, 1);
        vt[16] = mkv(1, 32'h7c, 32'hf00,  5, 0, 6, C_ADD,  0, 1, 1,  1, 32'h78, 32'he00,  5, C_LW,   2, 1);
        vt[17] = mkv(1, 32'h7c, 32'hf00,  5, 0, 6, C_ADD,  0, 1, 1,  1, 32'h78, 32'he00,  5, C_LW,   2, 1);
        vt[18] = mkv(1, 32'h7c, 32'hf00,  5, 0, 6, C_ADD,  0, 1, 1,  1, 32'h78, 32'he00,  5, C_LW,   2, 1);
        vt[19] = mkv(1, 32'h7c, 32'hf00,  5, 0, 6, C_ADD,  0, 0, 1,  0, 32'h0,  32'h0,    0, C_NOP,  3, 1);
        vt[20] = mkv(1, 32'h7c, 32'hf00,  5, 0, 6, C_ADD,  0, 0, 0,  1, 32'h7c, 32'hf00,  6, C_ADD,  3, 1);
        vt[21] = mkv(1, 32'h80, 32'h1000, 1, 2, 10, C_ADD, 1, 0, 0,  0, 32'h0,  32'h0,    0, C_NOP,  3, 2);
        vt[22] = mkv(1, 32'h84, 32'h1100, 1, 2, 11, C_ADD, 1, 1, 0,  0, 32'h0,  32'h0,    0, C_NOP,  3, 3);

        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, C_NOP, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            step(vt[i], i);
        end

        // Twenty load-use stalls: 16-bit counter keeps counting, 4-bit one pins at 15.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(1'b1, 32'h200 + 32'(i * 8), 32'h55, 5'd1, 5'd0, 5'd5, C_LW, 1'b0, 1'b0);
            #1;
            chk($sformatf("sat%0d load stall", i), 64'(bus.stall_if_id), 64'd0);
            @(negedge clk);
            drive(1'b1, 32'h204 + 32'(i * 8), 32'h66, 5'd5, 5'd2, 5'd6, C_ADD, 1'b0, 1'b0);
            #1;
            chk($sformatf("sat%0d use stall", i), 64'(bus.stall_if_id), 64'd1);
        end
        @(posedge clk);
        #1;
        chk("sat wide perf_stall_cnt", 64'(bus.perf_stall_cnt), 64'd23);
        chk("sat narrow perf_stall_cnt", 64'(bus_s.perf_stall_cnt), 64'd15);
        chk("sat narrow perf_flush_cnt", 64'(bus_s.perf_flush_cnt), 64'd3);
        chk("sat wide perf_flush_cnt", 64'(bus.perf_flush_cnt), 64'd3);

        // Asynchronous reset between edges discards the in-flight instruction.
        @(negedge clk);
        drive(1'b1, 32'h300, 32'h77, 5'd1, 5'd2, 5'd4, C_ADD, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("prereset ex_valid", 64'(bus.ex_valid), 64'd1);
        chk("prereset ex_pc", 64'(bus.ex_pc), 64'h300);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async reset");
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 32'h304, 32'h88, 5'd1, 5'd2, 5'd4, C_ADD, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("postreset ex_valid", 64'(bus.ex_valid), 64'd1);
        chk("postreset ex_pc", 64'(bus.ex_pc), 64'h304);
        chk("postreset ex_ctrl", 64'(bus.ex_ctrl), 64'(C_ADD));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
